// File: rtl/pool2d_stream.sv
// pool2d_stream: 2x2 / stride-2 max or average pooling over packed-lane
// AXI-Stream feature maps (row-major, channel-last). One row of partial
// window results is held in a register-file buffer; the completed window
// lands in a single output register that reloads without a bubble.
module pool2d_stream #(
    parameter int DATA_W   = 32,
    parameter int ELEM_W   = 8,
    parameter int MAX_FLEN = 32,
    parameter int MAX_CH   = 256
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic [DATA_W-1:0]   S_AXIS_TDATA,
    input  logic                S_AXIS_TVALID,
    output logic                S_AXIS_TREADY,
    input  logic                S_AXIS_TLAST,
    input  logic [DATA_W/8-1:0] S_AXIS_TKEEP,
    input  logic                S_AXIS_TUSER,
    output logic [DATA_W-1:0]   M_AXIS_TDATA,
    output logic                M_AXIS_TVALID,
    input  logic                M_AXIS_TREADY,
    output logic                M_AXIS_TLAST,
    output logic [DATA_W/8-1:0] M_AXIS_TKEEP,
    output logic                M_AXIS_TUSER,
    input  logic                pool_start,
    output logic                pool_done,
    input  logic [5:0]          flen,
    input  logic [8:0]          in_channel,
    input  logic                pool_mode,
    output logic                frame_err
);
    localparam int LANES  = DATA_W / ELEM_W;
    localparam int SW     = ELEM_W + 2;
    localparam int CW_MAX = MAX_CH / LANES;
    localparam int DEPTH  = (MAX_FLEN / 2) * CW_MAX;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // job configuration captured at start
    typedef struct packed {
        logic [5:0] flen;
        logic [8:0] cw;
        logic       mode;
    } cfg_t;

    // output register contents
    typedef struct packed {
        logic              valid;
        logic              last;
        logic [DATA_W-1:0] data;
    } obeat_t;

    state_t  state;
    cfg_t    cfg;
    obeat_t  ob;
    logic [8:0] cg;
    logic [5:0] col;
    logic [5:0] row;

    logic [LANES-1:0][ELEM_W-1:0] s_lane;
    logic [LANES-1:0][ELEM_W-1:0] res_w;
    logic [LANES-1:0][SW-1:0]     rd_w;
    logic [LANES-1:0][SW-1:0]     nxt_w;
    logic [LANES-1:0][SW-1:0]     buf_mem [DEPTH];

    logic [AW-1:0] addr;
    logic          s_fire;
    logic          first;
    logic          win_done;
    logic          last_beat;
    logic          unused_in;

    assign unused_in = ^{S_AXIS_TKEEP, S_AXIS_TUSER};

    assign s_lane        = S_AXIS_TDATA;
    assign S_AXIS_TREADY = (state == RUN) && (!ob.valid || M_AXIS_TREADY);
    assign s_fire        = S_AXIS_TVALID && S_AXIS_TREADY;

    assign M_AXIS_TDATA  = ob.data;
    assign M_AXIS_TVALID = ob.valid;
    assign M_AXIS_TLAST  = ob.last;
    assign M_AXIS_TKEEP  = '1;
    assign M_AXIS_TUSER  = 1'b0;

    // window position decode and buffer address for the current beat
    always_comb begin
        first     = !row[0] && !col[0];
        win_done  = row[0] && col[0];
        last_beat = (cg == cfg.cw - 9'd1) && (col == cfg.flen - 6'd1) &&
                    (row == cfg.flen - 6'd1);
        addr      = AW'(col[5:1]) * AW'(cfg.cw) + AW'(cg);
        rd_w      = buf_mem[addr];
    end

    // one combiner per lane
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        pool2d_lane #(.ELEM_W(ELEM_W)) u_lane (
            .mode  (cfg.mode),
            .first (first),
            .acc   (rd_w[k]),
            .x     (s_lane[k]),
            .nxt   (nxt_w[k]),
            .res   (res_w[k])
        );
    end

    // partial-window buffer; the window-completing beat goes to the output register instead
    always_ff @(posedge CLK) begin
        if (s_fire && !win_done)
            buf_mem[addr] <= nxt_w;
    end

    // job FSM, position counters, output register and status flags
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state     <= IDLE;
            cfg       <= '0;
            cg        <= '0;
            col       <= '0;
            row       <= '0;
            ob        <= '0;
            pool_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // a handshake empties the register; a window completion below overrides it
            if (ob.valid && M_AXIS_TREADY) begin
                ob.valid <= 1'b0;
                ob.last  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (pool_start) begin
                        cfg.flen  <= flen;
                        cfg.cw    <= in_channel / 9'(LANES);
                        cfg.mode  <= pool_mode;
                        cg        <= '0;
                        col       <= '0;
                        row       <= '0;
                        frame_err <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (s_fire) begin
                        if (win_done) begin
                            ob.valid <= 1'b1;
                            ob.last  <= last_beat;
                            ob.data  <= res_w;
                        end
                        if (S_AXIS_TLAST != last_beat)
                            frame_err <= 1'b1;
                        if (cg == cfg.cw - 9'd1) begin
                            cg <= '0;
                            if (col == cfg.flen - 6'd1) begin
                                col <= '0;
                                row <= (row == cfg.flen - 6'd1) ? 6'd0 : row + 6'd1;
                            end else begin
                                col <= col + 6'd1;
                            end
                        end else begin
                            cg <= cg + 9'd1;
                        end
                        if (last_beat)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!ob.valid || (M_AXIS_TREADY && ob.last)) begin
                        pool_done <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (!pool_start) begin
                        pool_done <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// pool2d_lane: per-lane window combiner. Partial results are kept ELEM_W+2
// bits wide so four signed elements can be summed without overflow; max
// results are simply sign-extended into the same width.
module pool2d_lane #(
    parameter int ELEM_W = 8,
    parameter int SW     = ELEM_W + 2
) (
    input  logic              mode,
    input  logic              first,
    input  logic [SW-1:0]     acc,
    input  logic [ELEM_W-1:0] x,
    output logic [SW-1:0]     nxt,
    output logic [ELEM_W-1:0] res
);
    logic signed [SW-1:0] xs;
    logic signed [SW-1:0] accs;

    // combine stored partial with the new element; avg result is sum >>> 2
    always_comb begin
        xs   = {{(SW-ELEM_W){x[ELEM_W-1]}}, x};
        accs = acc;
        if (first)
            nxt = xs;
        else if (mode)
            nxt = accs + xs;
        else
            nxt = (xs > accs) ? xs : accs;
        res = mode ? nxt[ELEM_W+1:2] : nxt[ELEM_W-1:0];
    end
endmodule

// File: tb/tb_pool2d_stream.sv
// Directed bench for pool2d_stream: reset state, max/avg windows, backpressure,
// framing errors, mid-job reset and the start/done handshake.
module tb_pool2d_stream;
    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic [31:0] S_AXIS_TDATA = '0;
    logic        S_AXIS_TVALID = 1'b0;
    logic        S_AXIS_TREADY;
    logic        S_AXIS_TLAST = 1'b0;
    logic [3:0]  S_AXIS_TKEEP = 4'hF;
    logic        S_AXIS_TUSER = 1'b0;
    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY = 1'b1;
    logic        M_AXIS_TLAST;
    logic [3:0]  M_AXIS_TKEEP;
    logic        M_AXIS_TUSER;
    logic        pool_start = 1'b0;
    logic        pool_done;
    logic [5:0]  flen = '0;
    logic [8:0]  in_channel = '0;
    logic        pool_mode = 1'b0;
    logic        frame_err;

    int checks = 0;
    int failures = 0;
    bit rand_ready = 0;
    int stall_changes = 0;
    logic [31:0] beat_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] cap_d[$];
    logic        cap_l[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_d = '0;
    logic        prev_l = 1'b0;

    pool2d_stream dut (
        .CLK(CLK), .RESETN(RESETN),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID),
        .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TLAST(S_AXIS_TLAST),
        .S_AXIS_TKEEP(S_AXIS_TKEEP), .S_AXIS_TUSER(S_AXIS_TUSER),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TLAST(M_AXIS_TLAST),
        .M_AXIS_TKEEP(M_AXIS_TKEEP), .M_AXIS_TUSER(M_AXIS_TUSER),
        .pool_start(pool_start), .pool_done(pool_done),
        .flen(flen), .in_channel(in_channel), .pool_mode(pool_mode),
        .frame_err(frame_err)
    );

    always #5 CLK = ~CLK;

    // sink ready: always 1 unless random backpressure is enabled
    always @(posedge CLK) begin
        #1;
        M_AXIS_TREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // output monitor: capture handshakes, count data changes while stalled
    always @(negedge CLK) begin
        if (!RESETN) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (M_AXIS_TDATA !== prev_d || M_AXIS_TLAST !== prev_l ||
                               M_AXIS_TVALID !== 1'b1))
                stall_changes++;
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                cap_d.push_back(M_AXIS_TDATA);
                cap_l.push_back(M_AXIS_TLAST);
            end
            prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
            prev_d = M_AXIS_TDATA;
            prev_l = M_AXIS_TLAST;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // reference: direct 2x2 window evaluation over the whole frame in beat_q
    task automatic build_exp(input int fl, input int cw, input bit avg);
        logic [31:0] w;
        logic [31:0] bt;
        int v[4];
        int acc;
        exp_q.delete();
        for (int wr = 0; wr < fl / 2; wr++)
            for (int wc = 0; wc < fl / 2; wc++)
                for (int g = 0; g < cw; g++) begin
                    w = '0;
                    for (int k = 0; k < 4; k++) begin
                        for (int d = 0; d < 4; d++) begin
                            bt = beat_q[((2 * wr + d / 2) * fl + 2 * wc + d % 2) * cw + g];
                            v[d] = int'($signed(bt[k*8 +: 8]));
                        end
                        if (avg) begin
                            acc = (v[0] + v[1] + v[2] + v[3]) >>> 2;
                        end else begin
                            acc = v[0];
                            for (int j = 1; j < 4; j++)
                                if (v[j] > acc) acc = v[j];
                        end
                        w[k*8 +: 8] = acc[7:0];
                    end
                    exp_q.push_back(w);
                end
    endtask

    task automatic start_job(input logic [5:0] fl, input logic [8:0] ch, input logic md);
        cap_d.delete();
        cap_l.delete();
        stall_changes = 0;
        flen = fl;
        in_channel = ch;
        pool_mode = md;
        pool_start = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        S_AXIS_TDATA = d;
        S_AXIS_TLAST = l;
        S_AXIS_TVALID = 1'b1;
        @(negedge CLK);
        while (!S_AXIS_TREADY && n < 300) begin
            n++;
            @(negedge CLK);
        end
        if (!S_AXIS_TREADY) begin
            checks++;
            failures++;
            $display("FAIL send_beat_timeout tready=%b required=1", S_AXIS_TREADY);
        end
        @(posedge CLK);
        #1;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST = 1'b0;
    endtask

    task automatic send_all(input int early);
        for (int i = 0; i < beat_q.size(); i++)
            send_beat(beat_q[i], (i == beat_q.size() - 1) || (i == early));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (pool_done !== 1'b1 && n < 1000) begin
            n++;
            @(negedge CLK);
        end
        checks++;
        if (pool_done !== 1'b1) begin
            failures++;
            $display("FAIL wait_done pool_done=%b required=1", pool_done);
        end
    endtask

    task automatic end_job();
        int n;
        n = 0;
        pool_start = 1'b0;
        @(negedge CLK);
        while (pool_done !== 1'b0 && n < 50) begin
            n++;
            @(negedge CLK);
        end
        checks++;
        if (pool_done !== 1'b0) begin
            failures++;
            $display("FAIL end_job pool_done=%b required=0", pool_done);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        #12;
        checks += 8;
        if (S_AXIS_TREADY !== 1'b0) begin failures++; $display("FAIL rst_tready got=%b exp=0", S_AXIS_TREADY); end
        if (M_AXIS_TVALID !== 1'b0) begin failures++; $display("FAIL rst_tvalid got=%b exp=0", M_AXIS_TVALID); end
        if (M_AXIS_TLAST !== 1'b0) begin failures++; $display("FAIL rst_tlast got=%b exp=0", M_AXIS_TLAST); end
        if (M_AXIS_TDATA !== 32'h0) begin failures++; $display("FAIL rst_tdata got=%h exp=0", M_AXIS_TDATA); end
        if (pool_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", pool_done); end
        if (frame_err !== 1'b0) begin failures++; $display("FAIL rst_ferr got=%b exp=0", frame_err); end
        if (M_AXIS_TKEEP !== 4'hF) begin failures++; $display("FAIL rst_tkeep got=%h exp=f", M_AXIS_TKEEP); end
        if (M_AXIS_TUSER !== 1'b0) begin failures++; $display("FAIL rst_tuser got=%b exp=0", M_AXIS_TUSER); end
        @(posedge CLK);
        #1;
        RESETN = 1'b1;
        @(negedge CLK);
        checks++;
        if (S_AXIS_TREADY !== 1'b0) begin failures++; $display("FAIL idle_tready got=%b exp=0", S_AXIS_TREADY); end
        @(posedge CLK);
        #1;
    endtask

    // leaves pool_start high for the hold test that follows
    task automatic test_max();
        beat_q = '{32'h01020304, 32'h7F000000, 32'h80FFFF05, 32'h00000010};
        start_job(6'd2, 9'd4, 1'b0);
        send_all(-1);
        @(negedge CLK);
        checks += 4;
        if (M_AXIS_TVALID !== 1'b1) begin failures++; $display("FAIL max_valid got=%b exp=1", M_AXIS_TVALID); end
        if (M_AXIS_TDATA !== 32'h7F020310) begin failures++; $display("FAIL max_data got=%h exp=7f020310", M_AXIS_TDATA); end
        if (M_AXIS_TLAST !== 1'b1) begin failures++; $display("FAIL max_last got=%b exp=1", M_AXIS_TLAST); end
        if (pool_done !== 1'b0) begin failures++; $display("FAIL max_done_early got=%b exp=0", pool_done); end
        @(negedge CLK);
        checks += 2;
        if (pool_done !== 1'b1) begin failures++; $display("FAIL max_done_plus2 got=%b exp=1", pool_done); end
        if (cap_d.size() !== 1) begin failures++; $display("FAIL max_count got=%0d exp=1", cap_d.size()); end
    endtask

    task automatic test_start_hold();
        int rdy_seen;
        rdy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (S_AXIS_TREADY) rdy_seen++;
        end
        checks += 2;
        if (pool_done !== 1'b1) begin failures++; $display("FAIL hold_done got=%b exp=1", pool_done); end
        if (rdy_seen !== 0) begin failures++; $display("FAIL hold_restart tready_cycles=%0d exp=0", rdy_seen); end
        @(posedge CLK);
        #1;
        pool_start = 1'b0;
        @(negedge CLK);
        checks++;
        if (pool_done !== 1'b1) begin failures++; $display("FAIL drop_same_cycle got=%b exp=1", pool_done); end
        @(negedge CLK);
        checks++;
        if (pool_done !== 1'b0) begin failures++; $display("FAIL drop_next_cycle got=%b exp=0", pool_done); end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_avg();
        logic [31:0] got;
        beat_q = '{32'h807FFF03, 32'h807FFF04, 32'h807FFFFF, 32'h807FFEFD};
        start_job(6'd2, 9'd4, 1'b1);
        send_all(-1);
        wait_done();
        got = (cap_d.size() > 0) ? cap_d[0] : 'x;
        checks += 2;
        if (got !== 32'h807FFE00) begin failures++; $display("FAIL avg_data got=%h exp=807ffe00", got); end
        if (frame_err !== 1'b0) begin failures++; $display("FAIL avg_ferr got=%b exp=0", frame_err); end
        end_job();
    endtask

    task automatic test_ramp_backpressure();
        logic [31:0] b;
        logic [31:0] got;
        logic        gl;
        beat_q.delete();
        for (int i = 0; i < 32; i++) begin
            for (int k = 0; k < 4; k++) b[k*8 +: 8] = 8'((i * 4 + k) * 5 + 8'h90);
            beat_q.push_back(b);
        end
        build_exp(4, 2, 1'b1);
        rand_ready = 1;
        start_job(6'd4, 9'd8, 1'b1);
        send_all(-1);
        wait_done();
        rand_ready = 0;
        checks += 2;
        if (cap_d.size() !== 8) begin failures++; $display("FAIL ramp_count got=%0d exp=8", cap_d.size()); end
        if (stall_changes !== 0) begin failures++; $display("FAIL ramp_stall_stable changes=%0d exp=0", stall_changes); end
        for (int i = 0; i < 8; i++) begin
            got = (i < cap_d.size()) ? cap_d[i] : 'x;
            gl  = (i < cap_l.size()) ? cap_l[i] : 1'bx;
            checks += 2;
            if (got !== exp_q[i]) begin failures++; $display("FAIL ramp_data[%0d] got=%h exp=%h", i, got, exp_q[i]); end
            if (gl !== (i == 7)) begin failures++; $display("FAIL ramp_last[%0d] got=%b exp=%b", i, gl, (i == 7)); end
        end
        end_job();
    endtask

    task automatic fill_frame16(input int seed);
        logic [31:0] b;
        beat_q.delete();
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 4; k++) b[k*8 +: 8] = 8'(i * 37 + k * 71 + seed);
            beat_q.push_back(b);
        end
        build_exp(4, 1, 1'b0);
    endtask

    task automatic test_frame_err();
        logic [31:0] got;
        fill_frame16(3);
        start_job(6'd4, 9'd4, 1'b0);
        send_all(5);
        wait_done();
        checks += 2;
        if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_set got=%b exp=1", frame_err); end
        if (cap_d.size() !== 4) begin failures++; $display("FAIL ferr_count got=%0d exp=4", cap_d.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < cap_d.size()) ? cap_d[i] : 'x;
            checks++;
            if (got !== exp_q[i]) begin failures++; $display("FAIL ferr_data[%0d] got=%h exp=%h", i, got, exp_q[i]); end
        end
        end_job();
        fill_frame16(100);
        start_job(6'd4, 9'd4, 1'b0);
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_clear got=%b exp=0", frame_err); end
        send_all(-1);
        wait_done();
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_clean_job got=%b exp=0", frame_err); end
        end_job();
    endtask

    task automatic test_reset_midrun();
        logic [31:0] got;
        fill_frame16(9);
        start_job(6'd4, 9'd4, 1'b0);
        for (int i = 0; i < 5; i++) send_beat(beat_q[i], 1'b0);
        S_AXIS_TVALID = 1'b1;
        pool_start = 1'b0;
        RESETN = 1'b0;
        #1;
        checks += 3;
        if (S_AXIS_TREADY !== 1'b0) begin failures++; $display("FAIL mid_rst_tready got=%b exp=0", S_AXIS_TREADY); end
        if (M_AXIS_TVALID !== 1'b0) begin failures++; $display("FAIL mid_rst_tvalid got=%b exp=0", M_AXIS_TVALID); end
        if (pool_done !== 1'b0) begin failures++; $display("FAIL mid_rst_done got=%b exp=0", pool_done); end
        repeat (2) @(posedge CLK);
        #1;
        RESETN = 1'b1;
        @(negedge CLK);
        checks++;
        if (S_AXIS_TREADY !== 1'b0) begin failures++; $display("FAIL mid_rst_idle got=%b exp=0", S_AXIS_TREADY); end
        S_AXIS_TVALID = 1'b0;
        @(posedge CLK);
        #1;
        fill_frame16(50);
        start_job(6'd4, 9'd4, 1'b0);
        send_all(-1);
        wait_done();
        checks++;
        if (cap_d.size() !== 4) begin failures++; $display("FAIL post_rst_count got=%0d exp=4", cap_d.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < cap_d.size()) ? cap_d[i] : 'x;
            checks++;
            if (got !== exp_q[i]) begin failures++; $display("FAIL post_rst_data[%0d] got=%h exp=%h", i, got, exp_q[i]); end
        end
        end_job();
    endtask

    initial begin
        test_reset();
        test_max();
        test_start_hold();
        test_avg();
        test_ramp_backpressure();
        test_frame_err();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
